// File: rtl/gamerom_loader.sv
// gamerom_loader
//   Fills the 16-bit game ROM through its write port from an 8-bit byte
//   stream (for example the ESP32/SPI OSD download path). Bytes are paired
//   big-endian into 68k words and written at sequential word addresses from
//   0. The CPU is held in reset while a load is in progress.
//
//   Optional build macro: GAMEROM_LOADER_CSUM_EN
//     When defined, adds output csum[15:0], the mod-2^16 sum of all words
//     written during the current/last load.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       one-cycle pulse: begin a load (ignored while busy)
//   byte_valid  byte_data valid
//   byte_data   stream byte
//   byte_last   final byte of image, sampled with byte_valid
//   byte_ready  loader accepts a byte this cycle (registered)
//   we_b        ROM write enable
//   addr_b      ROM word address
//   din_b       ROM write data
//   busy        load in progress
//   done        last load finished (level)
//   overflow    image exceeded MAX_WORDS
//   cpu_hold    hold CPU in reset
//   word_count  words written in current/last load
//   csum        word checksum (GAMEROM_LOADER_CSUM_EN only)
//
// State table:
//   IDLE  | waiting for start after reset
//   HI    | waiting for the high byte of the next word
//   LO    | waiting for the low byte of the next word
//   WRITE | one-cycle ROM write of the assembled word
//   DRAIN | ROM full, discarding bytes until byte_last
//   DONE  | load finished, CPU released, start reloads

module gamerom_loader #(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 16384,
    parameter int BOOT_HOLD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [15:0]       din_b,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              cpu_hold,
`ifdef GAMEROM_LOADER_CSUM_EN
    output logic [15:0]       csum,
`endif
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MAX_WORDS - 1);
    localparam logic              BOOT_HOLD_L = (BOOT_HOLD != 0);

    state_t state;
    logic   final_flag;
    logic   xfer;

    // byte_ready is a register, so this has no combinational path back to
    // the source's byte_valid.
    assign xfer = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            final_flag <= 1'b0;
            byte_ready <= 1'b0;
            we_b       <= 1'b0;
            addr_b     <= '0;
            din_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            cpu_hold   <= BOOT_HOLD_L;
            word_count <= '0;
`ifdef GAMEROM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            // Write strobe lives for exactly the one cycle spent in WRITE.
            we_b <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_HI;
                        final_flag <= 1'b0;
                        byte_ready <= 1'b1;
                        addr_b     <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
`ifdef GAMEROM_LOADER_CSUM_EN
                        csum       <= '0;
`endif
                    end
                end

                ST_HI: begin
                    if (xfer) begin
                        din_b[15:8] <= byte_data;
                        if (byte_last) begin
                            // Odd-length image: pad the low byte.
                            din_b[7:0] <= 8'h00;
                            final_flag <= 1'b1;
                            state      <= ST_WRITE;
                            we_b       <= 1'b1;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= ST_LO;
                        end
                    end
                end

                ST_LO: begin
                    if (xfer) begin
                        din_b[7:0] <= byte_data;
                        final_flag <= byte_last;
                        state      <= ST_WRITE;
                        we_b       <= 1'b1;
                        byte_ready <= 1'b0;
                    end
                end

                ST_WRITE: begin
                    word_count <= word_count + (ADDR_W+1)'(1);
                    addr_b     <= addr_b + ADDR_W'(1);
`ifdef GAMEROM_LOADER_CSUM_EN
                    csum       <= csum + din_b;
`endif
                    if (final_flag) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (addr_b == LAST_ADDR) begin
                        // ROM full but image continues: swallow the rest.
                        state      <= ST_DRAIN;
                        byte_ready <= 1'b1;
                    end else begin
                        state      <= ST_HI;
                        byte_ready <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (xfer && byte_last) begin
                        state      <= ST_DONE;
                        byte_ready <= 1'b0;
                        overflow   <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gamerom_loader.md
Name: gamerom_loader

Overview:
- Fills the 16-bit game ROM through its write port (we_b/addr_b/din_b) from an 8-bit byte stream, e.g. the ESP32/SPI OSD download path.
- Pairs bytes big-endian into 68k words and writes them at sequential word addresses from 0.
- Holds the CPU in reset while loading and reports completion, word count and overflow.

Parameters:
- ADDR_W, 14, word address width of ROM write port
- MAX_WORDS, 16384, ROM capacity in words; 1 <= MAX_WORDS <= 2^ADDR_W
- BOOT_HOLD, 0, reset value of cpu_hold (1 = CPU held until first load completes)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a load
- byte_valid  in  1  byte_data valid
- byte_data  in  8  stream byte
- byte_last  in  1  qualifies final byte of image (sampled with byte_valid)
- byte_ready  out  1  loader accepts byte this cycle
- we_b  out  1  ROM write enable
- addr_b  out  ADDR_W  ROM word address
- din_b  out  16  ROM write data
- busy  out  1  load in progress
- done  out  1  last load finished (level)
- overflow  out  1  image exceeded MAX_WORDS
- cpu_hold  out  1  hold CPU in reset
- word_count  out  ADDR_W+1  words written in current/last load

Behaviour:
- Byte transfer occurs on a cycle with byte_valid && byte_ready. All outputs are registered.
- Reset values: state IDLE; byte_ready, we_b, busy, done and overflow are 0; addr_b, din_b and word_count are 0; cpu_hold = BOOT_HOLD.
- IDLE:
  - byte_ready = 0.
  - start -> HI; clears addr, word_count, done and overflow; sets busy and cpu_hold.
- HI:
  - byte_ready = 1; a transfer latches din_b[15:8].
  - Without byte_last -> LO.
  - With byte_last -> odd-length image: din_b[7:0] = 0x00, final flag set -> WRITE.
- LO:
  - byte_ready = 1; a transfer latches din_b[7:0] -> WRITE.
  - byte_last latched as the final flag.
- WRITE:
  - byte_ready = 0; we_b = 1 for exactly this one cycle, with addr_b = current address and din_b = assembled word.
  - word_count increments; addr_b increments on exit.
  - If final -> DONE.
  - Else if this was address MAX_WORDS-1 -> DRAIN.
  - Else -> HI.
- DRAIN:
  - byte_ready = 1; bytes are accepted and discarded, no writes.
  - A transfer with byte_last sets overflow -> DONE.
- DONE:
  - busy = 0, done = 1, cpu_hold = 0.
  - start -> same as from IDLE (reload).
- Throughput: 3 cycles per word minimum (HI, LO, WRITE); no combinational path from byte_valid to byte_ready.
- start is ignored while busy. byte_valid in IDLE/DONE is not accepted (ready = 0).
- we_b is never asserted outside WRITE. addr_b never reaches MAX_WORDS while we_b = 1.
- Reset mid-load: write aborts immediately (we_b = 0 next cycle), state -> IDLE, cpu_hold = BOOT_HOLD. ROM contents are partial and undefined.
- A gap in byte_valid stalls the state with no timeout. byte_last in WRITE is not sampled (ready = 0).

Optional Feature:
- Macro: GAMEROM_LOADER_CSUM_EN.
- Defined:
  - Adds output csum [15:0], reset 0 and cleared on start.
  - In WRITE, csum <= csum + din_b, mod 2^16; bytes discarded in DRAIN are excluded.
  - Valid once done = 1.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Even image: start, stream 12 34 56 78 (last on 78) -> writes addr0=0x1234, addr1=0x5678; word_count=2, done=1, overflow=0, cpu_hold=0.
- Odd image: stream AB CD EF (last on EF) -> addr0=0xABCD, addr1=0xEF00; word_count=2.
- Backpressure/gaps: random byte_valid idle cycles over 8 bytes -> same 4 words at addr 0..3; exactly one we_b per word; no writes during gaps.
- Overflow (MAX_WORDS=4): 11 bytes, last on 11th -> 4 writes addr0..3, all 11 bytes accepted, overflow=1, done=1, word_count=4.
- Reset/restart: assert reset after 3 bytes -> we_b=0, IDLE, cpu_hold=BOOT_HOLD. Then start during a later load -> ignored. Start in DONE -> reload from addr0 with done cleared.
- CSUM_EN: stream 00 01 FF FF 00 02 -> csum=0x0002 (wrap).
